// File: rtl/pe_ctrl_if.sv
// ============================================================================
// Module   : pe_ctrl_if
// Purpose  : Host / global-buffer / pe_array control bundle for pe_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pe_ctrl_if #(
  parameter int K_WIDTH    = 8,
  parameter int T_WIDTH    = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int SEL_WIDTH  = 3
) ();
  logic                  start_i;
  logic [K_WIDTH-1:0]    k_len_i;
  logic [T_WIDTH-1:0]    tiles_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  rd_en_o;
  logic [ADDR_WIDTH-1:0] rd_addr_o;
  logic                  clr_o;
  logic                  we_o;
  logic                  ob_we_o;
  logic [ADDR_WIDTH-1:0] ob_addr_o;
  logic [SEL_WIDTH-1:0]  ob_sel_o;

  // Host side: issues jobs and observes the sequencer outputs.
  modport master (
    output start_i, k_len_i, tiles_i,
    input  busy_o, done_o, rd_en_o, rd_addr_o, clr_o, we_o,
           ob_we_o, ob_addr_o, ob_sel_o
  );

  modport slave (
    input  start_i, k_len_i, tiles_i,
    output busy_o, done_o, rd_en_o, rd_addr_o, clr_o, we_o,
           ob_we_o, ob_addr_o, ob_sel_o
  );
endinterface

`default_nettype wire

// File: rtl/pe_ctrl.sv
// ============================================================================
// Module   : pe_ctrl
// Purpose  : Tiled matmul sequencer: operand reads, clr/we alignment, drain
//            wait and result write-back for a chain of pe_array columns.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_ctrl #(
  parameter int COLS       = 8,
  parameter int K_WIDTH    = 8,
  parameter int T_WIDTH    = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DRAIN_LAT  = 20
) (
  input  wire logic clk_i,
  input  wire logic rst_i,
  pe_ctrl_if.slave  bus
);

  localparam int c_SEL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int c_DRN_W = (DRAIN_LAT > 1) ? $clog2(DRAIN_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [K_WIDTH-1:0]    r_klen;
  logic [K_WIDTH-1:0]    r_k;
  logic [T_WIDTH-1:0]    r_tiles;
  logic [T_WIDTH-1:0]    r_t;
  logic [c_DRN_W-1:0]    r_dcnt;
  logic [c_SEL_W-1:0]    r_c;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [ADDR_WIDTH-1:0] r_ob_addr;
  logic                  r_clr;
  logic                  r_we;

  logic                  w_start_ok;
  logic                  w_k_last;
  logic                  w_d_last;
  logic                  w_c_last;
  logic                  w_t_last;

  logic                  w_busy;
  logic                  w_done;
  logic                  w_rd_en;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic                  w_ob_we;
  logic [ADDR_WIDTH-1:0] w_ob_addr;
  logic [c_SEL_W-1:0]    w_ob_sel;

  assign w_start_ok = bus.start_i && (bus.k_len_i != '0) && (bus.tiles_i != '0);
  assign w_k_last   = (r_k == r_klen - K_WIDTH'(1));
  assign w_d_last   = (r_dcnt == c_DRN_W'(DRAIN_LAT - 1));
  assign w_c_last   = (r_c == c_SEL_W'(COLS - 1));
  assign w_t_last   = (r_t == r_tiles - T_WIDTH'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    w_rd_en     = 1'b0;
    w_rd_addr   = '0;
    w_ob_we     = 1'b0;
    w_ob_addr   = '0;
    w_ob_sel    = '0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start_i) begin
          w_state_nxt = w_start_ok ? S_FEED : S_DONE;
        end
      end
      S_FEED: begin
        w_rd_en   = 1'b1;
        w_rd_addr = r_rd_addr;
        if (w_k_last) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_d_last) begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        w_ob_we   = 1'b1;
        w_ob_addr = r_ob_addr;
        w_ob_sel  = r_c;
        if (w_c_last) begin
          w_state_nxt = w_t_last ? S_DONE : S_FEED;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_busy      = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Address registers run continuously across tiles, so each tile base is
  // the previous base plus K (or COLS) without a multiplier; wrap is natural.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_klen    <= '0;
      r_tiles   <= '0;
      r_k       <= '0;
      r_t       <= '0;
      r_dcnt    <= '0;
      r_c       <= '0;
      r_rd_addr <= '0;
      r_ob_addr <= '0;
      r_clr     <= 1'b0;
      r_we      <= 1'b0;
    end else begin
      r_clr <= (r_state == S_FEED) && (r_k == '0);
      r_we  <= (r_state == S_FEED) && w_k_last;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_klen    <= bus.k_len_i;
            r_tiles   <= bus.tiles_i;
            r_k       <= '0;
            r_t       <= '0;
            r_dcnt    <= '0;
            r_c       <= '0;
            r_rd_addr <= '0;
            r_ob_addr <= '0;
          end
        end
        S_FEED: begin
          r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
          r_k       <= w_k_last ? '0 : r_k + K_WIDTH'(1);
        end
        S_DRAIN: begin
          r_dcnt <= w_d_last ? '0 : r_dcnt + c_DRN_W'(1);
        end
        S_WRITE: begin
          r_ob_addr <= r_ob_addr + ADDR_WIDTH'(1);
          r_c       <= w_c_last ? '0 : r_c + c_SEL_W'(1);
          if (w_c_last && !w_t_last) begin
            r_t <= r_t + T_WIDTH'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy_o    = w_busy;
  assign bus.done_o    = w_done;
  assign bus.rd_en_o   = w_rd_en;
  assign bus.rd_addr_o = w_rd_addr;
  assign bus.clr_o     = r_clr;
  assign bus.we_o      = r_we;
  assign bus.ob_we_o   = w_ob_we;
  assign bus.ob_addr_o = w_ob_addr;
  assign bus.ob_sel_o  = w_ob_sel;

endmodule

`default_nettype wire

// File: tb/tb_pe_ctrl.sv
// ============================================================================
// Module   : tb_pe_ctrl
// Purpose  : Directed self-checking bench for pe_ctrl (cycle n = window after
//            clock edge n; start driven in cycle 0 is sampled at edge 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_ctrl;

  logic clk;
  logic rst;

  pe_ctrl_if #(.K_WIDTH(8), .T_WIDTH(8), .ADDR_WIDTH(10), .SEL_WIDTH(3)) if0 ();
  pe_ctrl_if #(.K_WIDTH(8), .T_WIDTH(8), .ADDR_WIDTH(4),  .SEL_WIDTH(3)) if1 ();

  pe_ctrl #(.COLS(8), .K_WIDTH(8), .T_WIDTH(8), .ADDR_WIDTH(10), .DRAIN_LAT(20)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if0)
  );

  pe_ctrl #(.COLS(8), .K_WIDTH(8), .T_WIDTH(8), .ADDR_WIDTH(4), .DRAIN_LAT(20)) u_dut_w (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] rd_addr_q[$];
  int          rd_cyc_q[$];
  int          clr_q[$];
  int          we_q[$];
  logic [31:0] ob_addr_q[$];
  logic [31:0] ob_sel_q[$];
  int          ob_cyc_q[$];
  int          done_q[$];
  int          busy_low;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic st, input int k, input int t);
    if (sel == 0) begin
      if0.start_i = st; if0.k_len_i = 8'(k); if0.tiles_i = 8'(t);
    end else begin
      if1.start_i = st; if1.k_len_i = 8'(k); if1.tiles_i = 8'(t);
    end
  endtask

  task automatic sample(input int sel, input int cyc);
    logic rd_en, clr, we, ob_we, done, busy;
    logic [31:0] ra, oa, os;
    if (sel == 0) begin
      rd_en = if0.rd_en_o; clr = if0.clr_o; we = if0.we_o; ob_we = if0.ob_we_o;
      done = if0.done_o; busy = if0.busy_o;
      ra = 32'(if0.rd_addr_o); oa = 32'(if0.ob_addr_o); os = 32'(if0.ob_sel_o);
    end else begin
      rd_en = if1.rd_en_o; clr = if1.clr_o; we = if1.we_o; ob_we = if1.ob_we_o;
      done = if1.done_o; busy = if1.busy_o;
      ra = 32'(if1.rd_addr_o); oa = 32'(if1.ob_addr_o); os = 32'(if1.ob_sel_o);
    end
    if (rd_en === 1'b1) begin rd_addr_q.push_back(ra); rd_cyc_q.push_back(cyc); end
    if (clr === 1'b1) clr_q.push_back(cyc);
    if (we === 1'b1) we_q.push_back(cyc);
    if (ob_we === 1'b1) begin
      ob_addr_q.push_back(oa); ob_sel_q.push_back(os); ob_cyc_q.push_back(cyc);
    end
    if (done === 1'b1) done_q.push_back(cyc);
    if (busy === 1'b0 && busy_low < 0) busy_low = cyc;
  endtask

  // Runs one job from cycle 0 until one cycle past done_o (or maxc cycles).
  // With hold set, start stays high and k_len is changed mid-job.
  task automatic run_job(input int sel, input int k, input int t, input bit hold, input int maxc);
    rd_addr_q.delete(); rd_cyc_q.delete(); clr_q.delete(); we_q.delete();
    ob_addr_q.delete(); ob_sel_q.delete(); ob_cyc_q.delete(); done_q.delete();
    busy_low = -1;
    drive(sel, 1'b1, k, t);
    for (int c = 1; c <= maxc; c++) begin
      step();
      if (c == 1) drive(sel, hold, hold ? k + 5 : k, t);
      sample(sel, c);
      if (done_q.size() > 0 && c > done_q[0]) break;
    end
  endtask

  initial begin
    int cnt;
    bit seen;
    rst = 1'b1;
    drive(0, 1'b0, 0, 0);
    drive(1, 1'b0, 0, 0);
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_busy",  32'(if0.busy_o),    0);
    chk("rst_done",  32'(if0.done_o),    0);
    chk("rst_rd_en", 32'(if0.rd_en_o),   0);
    chk("rst_clr",   32'(if0.clr_o),     0);
    chk("rst_we",    32'(if0.we_o),      0);
    chk("rst_ob_we", 32'(if0.ob_we_o),   0);
    chk("rst_addr",  32'(if0.rd_addr_o), 0);

    // Single tile K=4 T=1
    run_job(0, 4, 1, 1'b0, 60);
    chk("st_rd_cnt", rd_addr_q.size(), 4);
    for (int i = 0; i < rd_addr_q.size(); i++) begin
      chk("st_rd_addr", rd_addr_q[i], i);
      chk("st_rd_cyc", rd_cyc_q[i], i + 1);
    end
    chk("st_clr_cnt", clr_q.size(), 1);
    if (clr_q.size() > 0) chk("st_clr_cyc", clr_q[0], 2);
    chk("st_we_cnt", we_q.size(), 1);
    if (we_q.size() > 0) chk("st_we_cyc", we_q[0], 5);
    chk("st_ob_cnt", ob_addr_q.size(), 8);
    for (int i = 0; i < ob_addr_q.size(); i++) begin
      chk("st_ob_addr", ob_addr_q[i], i);
      chk("st_ob_sel", ob_sel_q[i], i);
      chk("st_ob_cyc", ob_cyc_q[i], i + 25);
    end
    chk("st_done_cnt", done_q.size(), 1);
    if (done_q.size() > 0) chk("st_done_cyc", done_q[0], 33);
    chk("st_busy_low", busy_low, 34);

    // Multi tile K=3 T=3: tile period 3+20+8 = 31 cycles
    run_job(0, 3, 3, 1'b0, 150);
    chk("mt_rd_cnt", rd_addr_q.size(), 9);
    for (int i = 0; i < rd_addr_q.size(); i++) chk("mt_rd_addr", rd_addr_q[i], i);
    chk("mt_ob_cnt", ob_addr_q.size(), 24);
    for (int i = 0; i < ob_addr_q.size(); i++) begin
      chk("mt_ob_addr", ob_addr_q[i], i);
      chk("mt_ob_sel", ob_sel_q[i], i % 8);
    end
    chk("mt_clr_cnt", clr_q.size(), 3);
    chk("mt_we_cnt", we_q.size(), 3);
    if (clr_q.size() > 1) chk("mt_clr1_cyc", clr_q[1], 33);
    chk("mt_done_cnt", done_q.size(), 1);
    if (done_q.size() > 0) chk("mt_done_cyc", done_q[0], 94);

    // K=1 T=1
    run_job(0, 1, 1, 1'b0, 60);
    chk("k1_clr_cnt", clr_q.size(), 1);
    chk("k1_we_cnt", we_q.size(), 1);
    if (clr_q.size() > 0) chk("k1_clr_cyc", clr_q[0], 2);
    if (we_q.size() > 0) chk("k1_we_cyc", we_q[0], 2);
    if (done_q.size() > 0) chk("k1_done_cyc", done_q[0], 30);

    // K=0 and T=0 degenerate jobs
    run_job(0, 0, 5, 1'b0, 20);
    chk("k0_rd_cnt", rd_addr_q.size(), 0);
    chk("k0_ob_cnt", ob_addr_q.size(), 0);
    chk("k0_done_cnt", done_q.size(), 1);
    if (done_q.size() > 0) chk("k0_done_cyc", done_q[0], 1);
    chk("k0_busy_low", busy_low, 2);
    run_job(0, 3, 0, 1'b0, 20);
    chk("t0_rd_cnt", rd_addr_q.size(), 0);
    chk("t0_ob_cnt", ob_addr_q.size(), 0);
    chk("t0_done_cnt", done_q.size(), 1);
    if (done_q.size() > 0) chk("t0_done_cyc", done_q[0], 1);

    // start held high through a K=4 job; k_len changed while busy
    run_job(0, 4, 1, 1'b1, 60);
    chk("hold_rd_cnt", rd_addr_q.size(), 4);
    chk("hold_done_cnt", done_q.size(), 1);
    if (done_q.size() > 0) chk("hold_done_cyc", done_q[0], 33);
    chk("hold_busy_low", busy_low, 34);
    step();
    chk("hold_restart_rd", 32'(if0.rd_en_o), 1);
    chk("hold_restart_addr", 32'(if0.rd_addr_o), 0);
    drive(0, 1'b0, 0, 0);
    cnt = 1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (if0.rd_en_o === 1'b1) cnt++;
      if (if0.done_o === 1'b1) begin seen = 1'b1; break; end
    end
    chk("hold2_done", 32'(seen), 1);
    chk("hold2_rd_cnt", cnt, 9);
    step();

    // Reset in cycle 10 of a K=4 T=2 job
    drive(0, 1'b1, 4, 2);
    step();
    drive(0, 1'b0, 4, 2);
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_busy",  32'(if0.busy_o),    0);
    chk("mr_rd_en", 32'(if0.rd_en_o),   0);
    chk("mr_ob_we", 32'(if0.ob_we_o),   0);
    chk("mr_clr",   32'(if0.clr_o),     0);
    chk("mr_we",    32'(if0.we_o),      0);
    chk("mr_done",  32'(if0.done_o),    0);
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (if0.done_o !== 1'b0 || if0.rd_en_o !== 1'b0 || if0.ob_we_o !== 1'b0) cnt++;
    end
    chk("mr_quiet", cnt, 0);
    run_job(0, 2, 1, 1'b0, 60);
    chk("mr_new_rd_cnt", rd_addr_q.size(), 2);
    for (int i = 0; i < rd_addr_q.size(); i++) chk("mr_new_rd_addr", rd_addr_q[i], i);

    // Address wrap on the 4-bit instance: K=6 T=3
    run_job(1, 6, 3, 1'b0, 150);
    chk("wr_rd_cnt", rd_addr_q.size(), 18);
    for (int i = 12; i < rd_addr_q.size(); i++) chk("wr_t2_rd_addr", rd_addr_q[i], i % 16);
    chk("wr_ob_cnt", ob_addr_q.size(), 24);
    for (int i = 16; i < ob_addr_q.size(); i++) chk("wr_t2_ob_addr", ob_addr_q[i], i % 16);
    chk("wr_done_cnt", done_q.size(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
